// File: rtl/apb_bridge_fsm_param.sv
// APB master controller for the AHB-to-APB bridge.
// Each accepted AHB transfer becomes one APB SETUP/ACCESS sequence. The block
// also handles PREADY wait states, PSLVERR, an optional wait-state timeout,
// decode errors and the two-cycle AHB ERROR response.
// Every output is decoded from the state register or taken from a holding
// register, so there is no combinational path from any input to any output.
module apb_bridge_fsm_param #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 3,
  parameter int TIMEOUT = 16
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic               VALID,
  input  logic               HWRITE,
  input  logic [ADDR_W-1:0]  HADDR,
  input  logic [NUM_SLV-1:0] TSELx,
  input  logic [DATA_W-1:0]  HWDATA,
  input  logic [DATA_W-1:0]  PRDATA,
  input  logic               PREADY,
  input  logic               PSLVERR,
  output logic [NUM_SLV-1:0] PSELx,
  output logic               PENABLE,
  output logic               PWRITE,
  output logic [ADDR_W-1:0]  PADDR,
  output logic [DATA_W-1:0]  PWDATA,
  output logic               HREADY_OUT,
  output logic [DATA_W-1:0]  HRDATA,
  output logic [1:0]         HRESP
);

  // The wait counter is at least one bit wide. With TIMEOUT=0 it is never
  // compared, but keeping it one bit wide avoids a zero-width vector.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [2:0] {
    IDLE,
    WWAIT,
    SETUP,
    ACCESS,
    ERR1,
    ERR2
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [NUM_SLV-1:0] sel_q;
  logic [CNT_W-1:0]   wait_cnt;
  logic               accept;

  // A new request is taken only in the two states that show HREADY_OUT=1.
  assign accept = VALID && ((state == IDLE) || (state == ERR2));

  // State register, asynchronously forced to IDLE by reset.
  always_ff @(posedge HCLK or posedge HRESETn) begin
    if (HRESETn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state selection and decoding of the state-only outputs.
  always_comb begin
    next_state = state;
    HREADY_OUT = 1'b0;
    HRESP      = 2'b00;
    PENABLE    = 1'b0;
    PSELx      = '0;
    case (state)
      IDLE, ERR2: begin
        HREADY_OUT = 1'b1;
        if (state == ERR2) begin
          HRESP = 2'b01;
        end
        if (VALID) begin
          if (!$onehot(TSELx)) begin
            next_state = ERR1;
          end else if (HWRITE) begin
            next_state = WWAIT;
          end else begin
            next_state = SETUP;
          end
        end else begin
          next_state = IDLE;
        end
      end
      WWAIT: begin
        next_state = SETUP;
      end
      SETUP: begin
        PSELx      = sel_q;
        next_state = ACCESS;
      end
      ACCESS: begin
        PSELx   = sel_q;
        PENABLE = 1'b1;
        if (PREADY) begin
          next_state = PSLVERR ? ERR1 : IDLE;
        end else if ((TIMEOUT > 0) && (wait_cnt == CNT_LAST)) begin
          next_state = ERR1;
        end
      end
      ERR1: begin
        HRESP      = 2'b01;
        next_state = ERR2;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Request holding registers. They are loaded on acceptance and hold their
  // values through idle periods so that PADDR and PWRITE stay stable.
  always_ff @(posedge HCLK or posedge HRESETn) begin
    if (HRESETn) begin
      PADDR  <= '0;
      PWRITE <= 1'b0;
      sel_q  <= '0;
    end else if (accept) begin
      PADDR  <= HADDR;
      PWRITE <= HWRITE;
      sel_q  <= TSELx;
    end
  end

  // Write data arrives in the cycle after acceptance, which is the WWAIT cycle.
  always_ff @(posedge HCLK or posedge HRESETn) begin
    if (HRESETn) begin
      PWDATA <= '0;
    end else if (state == WWAIT) begin
      PWDATA <= HWDATA;
    end
  end

  // Read data is captured only when a read completes without a slave error.
  always_ff @(posedge HCLK or posedge HRESETn) begin
    if (HRESETn) begin
      HRDATA <= '0;
    end else if ((state == ACCESS) && PREADY && !PSLVERR && !PWRITE) begin
      HRDATA <= PRDATA;
    end
  end

  // Wait-state counter: cleared in SETUP, and incremented on each PREADY=0
  // ACCESS cycle. It saturates rather than wrapping around.
  always_ff @(posedge HCLK or posedge HRESETn) begin
    if (HRESETn) begin
      wait_cnt <= '0;
    end else if (state == SETUP) begin
      wait_cnt <= '0;
    end else if ((state == ACCESS) && !PREADY && (wait_cnt != CNT_MAX)) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_apb_bridge_fsm_param.sv
// Self-checking bench for apb_bridge_fsm_param.
// It drives a fixed table of transfers and then a set of random ones. The
// expected latency, response and read data come from a transfer-level model.
// Hand-written sequences cover the disabled timeout, back-to-back requests
// and reset during ACCESS.
module tb_apb_bridge_fsm_param;

  localparam int TO = 4;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [2:0]  sel;
    logic [31:0] wdata;
    logic [31:0] prdata;
    int          waits;
    logic        slverr;
    int          exp_lat;
    logic [1:0]  exp_resp;
    logic [31:0] exp_hrdata;
  } txn_t;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } apb_log_t;

  logic        hclk;
  logic        hresetn;
  logic        valid;
  logic        hwrite;
  logic [31:0] haddr;
  logic [2:0]  tsel;
  logic [31:0] hwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  logic [2:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        hready_out;
  logic [31:0] hrdata;
  logic [1:0]  hresp;

  logic [2:0]  psel0;
  logic        penable0;
  logic        pwrite0;
  logic [31:0] paddr0;
  logic [31:0] pwdata0;
  logic        hready0;
  logic [31:0] hrdata0;
  logic [1:0]  hresp0;

  int checks = 0;
  int errors = 0;

  int          obs_lat;
  logic [1:0]  obs_resp;
  logic [31:0] obs_hrdata;
  int          obs_acc;
  int          obs_psel_cyc;
  int          obs_psel_first;
  int          obs_pen_first;
  int          obs_bad_sel;
  int          obs_err1;
  logic [2:0]  obs_psel;
  logic [31:0] obs_paddr;
  logic        obs_pwrite;
  logic [31:0] obs_pwdata;

  logic [31:0] model_hr;
  txn_t        tbl[10];

  apb_bridge_fsm_param #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(3), .TIMEOUT(TO)) dut (
    .HCLK(hclk), .HRESETn(hresetn), .VALID(valid), .HWRITE(hwrite),
    .HADDR(haddr), .TSELx(tsel), .HWDATA(hwdata), .PRDATA(prdata),
    .PREADY(pready), .PSLVERR(pslverr), .PSELx(psel), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .HREADY_OUT(hready_out),
    .HRDATA(hrdata), .HRESP(hresp)
  );

  apb_bridge_fsm_param #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(3), .TIMEOUT(0)) dut0 (
    .HCLK(hclk), .HRESETn(hresetn), .VALID(valid), .HWRITE(hwrite),
    .HADDR(haddr), .TSELx(tsel), .HWDATA(hwdata), .PRDATA(prdata),
    .PREADY(pready), .PSLVERR(pslverr), .PSELx(psel0), .PENABLE(penable0),
    .PWRITE(pwrite0), .PADDR(paddr0), .PWDATA(pwdata0), .HREADY_OUT(hready0),
    .HRDATA(hrdata0), .HRESP(hresp0)
  );

  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    hresetn = 1'b1;
    valid   = 1'b0;
    pready  = 1'b0;
    pslverr = 1'b0;
    repeat (2) step();
    hresetn = 1'b0;
    step();
  endtask

  // Transfer-level reference. A transfer reaches ACCESS two edges after
  // acceptance for a read and three for a write. ACCESS then lasts waits+1
  // cycles, or TO cycles if the slave stalls that long. An error adds one
  // cycle for ERR1. Read data changes only on a successful read.
  function automatic void model(input txn_t t, output int lat, output logic [1:0] resp,
                                output int acc, output int psel_cyc, output int base);
    bit err;
    int n;
    base = t.write ? 3 : 2;
    if ($countones(t.sel) != 1) begin
      lat = 2; resp = 2'b01; acc = 0; psel_cyc = 0;
      return;
    end
    if (t.waits >= TO) begin
      n = TO; err = 1'b1;
    end else begin
      n = t.waits + 1; err = t.slverr;
    end
    lat      = base + n + (err ? 1 : 0);
    resp     = err ? 2'b01 : 2'b00;
    acc      = n;
    psel_cyc = n + 1;
    if (!err && !t.write) model_hr = t.prdata;
  endfunction

  // Present one request, then play the APB slave until HREADY_OUT returns.
  task automatic applyStimulus(input txn_t t);
    int acc_seen;
    int cyc;
    obs_acc = 0; obs_psel_cyc = 0; obs_psel_first = -1; obs_pen_first = -1;
    obs_bad_sel = 0; obs_err1 = 0;
    valid = 1'b1; hwrite = t.write; haddr = t.addr; tsel = t.sel;
    hwdata = ~t.wdata; prdata = t.prdata; pready = 1'b0; pslverr = 1'b0;
    step();
    valid = 1'b0; hwdata = t.wdata; cyc = 1; acc_seen = 0;
    while (cyc < 300) begin
      if (psel != 3'b000) begin
        obs_psel_cyc++;
        if (obs_psel_first < 0) obs_psel_first = cyc;
        if ($countones(psel) != 1) obs_bad_sel++;
      end
      if (hresp == 2'b01 && !hready_out) obs_err1++;
      if (penable) begin
        if (obs_pen_first < 0) begin
          obs_pen_first = cyc; obs_psel = psel; obs_paddr = paddr;
          obs_pwrite = pwrite; obs_pwdata = pwdata;
        end
        obs_acc++;
        pready  = (acc_seen == t.waits);
        pslverr = t.slverr && pready;
        acc_seen++;
      end else begin
        pready = 1'b0; pslverr = 1'b0;
      end
      if (hready_out) break;
      step();
      cyc++;
      if (cyc == 2) hwdata = $urandom;
    end
    obs_lat = cyc; obs_resp = hresp; obs_hrdata = hrdata;
    pready = 1'b0; pslverr = 1'b0;
  endtask

  task automatic run_and_check(input txn_t t, input bit use_table, input string tag);
    int lat, acc, pc, base;
    logic [1:0]  resp;
    logic [31:0] exp_hr;
    model(t, lat, resp, acc, pc, base);
    exp_hr = model_hr;
    if (use_table) begin
      lat = t.exp_lat; resp = t.exp_resp; exp_hr = t.exp_hrdata;
    end
    applyStimulus(t);
    checkOutput({tag, " latency"}, obs_lat, lat);
    checkOutput({tag, " hresp"}, obs_resp, resp);
    checkOutput({tag, " hrdata"}, obs_hrdata, exp_hr);
    checkOutput({tag, " access cycles"}, obs_acc, acc);
    checkOutput({tag, " psel cycles"}, obs_psel_cyc, pc);
    checkOutput({tag, " err1 cycles"}, obs_err1, (resp == 2'b01) ? 1 : 0);
    checkOutput({tag, " psel onehot"}, obs_bad_sel, 0);
    if (pc > 0) begin
      checkOutput({tag, " psel first"}, obs_psel_first, base - 1);
      checkOutput({tag, " penable first"}, obs_pen_first, base);
      checkOutput({tag, " psel"}, obs_psel, t.sel);
      checkOutput({tag, " paddr"}, obs_paddr, t.addr);
      checkOutput({tag, " pwrite"}, obs_pwrite, t.write);
      if (t.write) checkOutput({tag, " pwdata"}, obs_pwdata, t.wdata);
    end
  endtask

  initial begin
    txn_t       t;
    apb_log_t   apb_log[$];
    apb_log_t   ent;
    int         stall_bad;
    int         k;
    logic       b_wr[3];
    logic [31:0] b_ad[3];
    logic [31:0] b_wd[3];

    tbl[0] = '{1'b0, 32'h0000_0040, 3'b010, 32'h0, 32'hDEAD_BEEF, 0, 1'b0, 3, 2'b00, 32'hDEAD_BEEF};
    tbl[1] = '{1'b1, 32'h0000_0010, 3'b001, 32'h1234_5678, 32'h0, 2, 1'b0, 6, 2'b00, 32'hDEAD_BEEF};
    tbl[2] = '{1'b0, 32'h0000_0020, 3'b100, 32'h0, 32'hCAFE_F00D, 1, 1'b1, 5, 2'b01, 32'hDEAD_BEEF};
    tbl[3] = '{1'b0, 32'h0000_0024, 3'b001, 32'h0, 32'h0BAD_C0DE, 0, 1'b0, 3, 2'b00, 32'h0BAD_C0DE};
    tbl[4] = '{1'b0, 32'h0000_0030, 3'b010, 32'h0, 32'h5555_AAAA, 100, 1'b0, 7, 2'b01, 32'h0BAD_C0DE};
    tbl[5] = '{1'b1, 32'h0000_0034, 3'b000, 32'hFFFF_0000, 32'h0, 0, 1'b0, 2, 2'b01, 32'h0BAD_C0DE};
    tbl[6] = '{1'b0, 32'h0000_0038, 3'b011, 32'h0, 32'h9999_9999, 0, 1'b0, 2, 2'b01, 32'h0BAD_C0DE};
    tbl[7] = '{1'b1, 32'h0000_003C, 3'b100, 32'hA5A5_A5A5, 32'h0, 3, 1'b0, 7, 2'b00, 32'h0BAD_C0DE};
    tbl[8] = '{1'b1, 32'h0000_0044, 3'b010, 32'h7777_0000, 32'h0, 4, 1'b0, 8, 2'b01, 32'h0BAD_C0DE};
    tbl[9] = '{1'b0, 32'h0000_0048, 3'b100, 32'h0, 32'h1111_2222, 3, 1'b0, 6, 2'b00, 32'h1111_2222};

    hresetn = 1'b1; valid = 1'b0; hwrite = 1'b0; haddr = '0; tsel = '0;
    hwdata = '0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
    #3;
    checkOutput("reset psel", psel, 3'b000);
    checkOutput("reset penable", penable, 1'b0);
    checkOutput("reset pwrite", pwrite, 1'b0);
    checkOutput("reset paddr", paddr, 32'h0);
    checkOutput("reset pwdata", pwdata, 32'h0);
    checkOutput("reset hrdata", hrdata, 32'h0);
    checkOutput("reset hresp", hresp, 2'b00);
    checkOutput("reset hready", hready_out, 1'b1);
    do_reset();
    model_hr = 32'h0;

    for (int i = 0; i < 10; i++) begin
      run_and_check(tbl[i], 1'b1, $sformatf("tbl%0d", i));
    end

    for (int i = 0; i < 40; i++) begin
      int r;
      t.write  = 1'($urandom_range(0, 1));
      t.addr   = $urandom;
      r        = $urandom_range(0, 9);
      if (r == 0)      t.sel = 3'b000;
      else if (r == 1) t.sel = 3'b111;
      else             t.sel = 3'(1 << $urandom_range(0, 2));
      t.wdata  = $urandom;
      t.prdata = $urandom;
      t.waits  = $urandom_range(0, 6);
      t.slverr = ($urandom_range(0, 5) == 0);
      t.exp_lat = 0; t.exp_resp = 2'b00; t.exp_hrdata = 32'h0;
      run_and_check(t, 1'b0, $sformatf("rnd%0d", i));
    end

    // The TIMEOUT=0 instance must stall on PREADY=0 without ever erroring.
    do_reset();
    valid = 1'b1; hwrite = 1'b0; haddr = 32'h60; tsel = 3'b100;
    step();
    valid = 1'b0;
    stall_bad = 0;
    repeat (100) begin
      if (hready0 || hresp0 != 2'b00) stall_bad++;
      step();
    end
    checkOutput("to0 stall flags", stall_bad, 0);
    checkOutput("to0 penable held", penable0, 1'b1);
    checkOutput("to4 recovered", hready_out, 1'b1);
    pready = 1'b1; prdata = 32'h7777_7777;
    step();
    pready = 1'b0;
    checkOutput("to0 done hready", hready0, 1'b1);
    checkOutput("to0 done hresp", hresp0, 2'b00);
    checkOutput("to0 done hrdata", hrdata0, 32'h7777_7777);

    // Write, read, write with VALID held: busy cycles must ignore the held
    // request, and the APB order must match the request order.
    b_wr[0] = 1'b1; b_ad[0] = 32'h100; b_wd[0] = 32'h1111_1111;
    b_wr[1] = 1'b0; b_ad[1] = 32'h200; b_wd[1] = 32'h0;
    b_wr[2] = 1'b1; b_ad[2] = 32'h300; b_wd[2] = 32'h3333_3333;
    k = 0; pready = 1'b1; pslverr = 1'b0; prdata = 32'h2222_2222;
    for (int c = 0; c < 40; c++) begin
      if (penable && pready) begin
        ent.write = pwrite; ent.addr = paddr; ent.wdata = pwdata;
        apb_log.push_back(ent);
      end
      if (hready_out) begin
        if (k < 3) begin
          valid = 1'b1; hwrite = b_wr[k]; haddr = b_ad[k]; tsel = 3'b001;
          if (b_wr[k]) hwdata = b_wd[k];
          k++;
        end else begin
          valid = 1'b0;
        end
      end
      step();
    end
    valid = 1'b0; pready = 1'b0;
    checkOutput("b2b count", apb_log.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < apb_log.size()) begin
        checkOutput($sformatf("b2b%0d write", i), apb_log[i].write, b_wr[i]);
        checkOutput($sformatf("b2b%0d addr", i), apb_log[i].addr, b_ad[i]);
        if (b_wr[i]) checkOutput($sformatf("b2b%0d wdata", i), apb_log[i].wdata, b_wd[i]);
      end
    end
    checkOutput("b2b hrdata", hrdata, 32'h2222_2222);

    // Reset during ACCESS must clear the outputs without waiting for a clock edge.
    valid = 1'b1; hwrite = 1'b0; haddr = 32'h500; tsel = 3'b001;
    step();
    valid = 1'b0;
    step();
    checkOutput("rst pre penable", penable, 1'b1);
    #2;
    hresetn = 1'b1;
    #1;
    checkOutput("rst psel", psel, 3'b000);
    checkOutput("rst penable", penable, 1'b0);
    checkOutput("rst hready", hready_out, 1'b1);
    checkOutput("rst hrdata", hrdata, 32'h0);
    checkOutput("rst paddr", paddr, 32'h0);
    hresetn = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
